// File: rtl/dual_port_sram_fifo_ctrl_pkg.sv
// Shared widths, depth and types for the SRAM-backed FIFO controller.
// Imported by the interface, the output buffer and the top.
package sram_fifo_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEPTH            = 1 << DEF_ADDR_WIDTH;
  localparam int ALMOST_THRESHOLD = 4;

  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  typedef logic [DEF_ADDR_WIDTH:0]   count_t;

endpackage

// File: rtl/dual_port_sram_fifo_ctrl_if.sv
// Push/pop handshake bundle of the SRAM FIFO controller.
// master = producer/consumer side, slave = FIFO side.
interface dual_port_sram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = sram_fifo_pkg::DEF_DATA_WIDTH
);

  logic                  Wr_Valid_In;
  logic [DATA_WIDTH-1:0] Wr_Data_In;
  logic                  Wr_Ready_Out;
  logic                  Rd_Valid_Out;
  logic [DATA_WIDTH-1:0] Rd_Data_Out;
  logic                  Rd_Ready_In;

  modport master (
    output Wr_Valid_In,
    output Wr_Data_In,
    output Rd_Ready_In,
    input  Wr_Ready_Out,
    input  Rd_Valid_Out,
    input  Rd_Data_Out
  );

  modport slave (
    input  Wr_Valid_In,
    input  Wr_Data_In,
    input  Rd_Ready_In,
    output Wr_Ready_Out,
    output Rd_Valid_Out,
    output Rd_Data_Out
  );

endinterface

// File: rtl/dual_port_sram_fifo_ctrl_out_buffer.sv
// Two-entry output skid buffer that absorbs SRAM read returns.
// Head entry is presented until popped; writes go behind it.
module sram_fifo_out_buffer
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [1:0]            occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  head_q;
  logic                  head_d;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;

  assign occ     = occ_q;
  assign valid   = (occ_q != 2'd0);
  assign rd_data = mem_q[head_q];

  // next entry contents, head index and occupancy
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    occ_d  = occ_q;
    if (wr_en) begin
      mem_d[head_q ^ occ_q[0]] = wr_data;
    end
    if (rd_en) begin
      head_d = ~head_q;
    end
    unique case (1'b1)
      wr_en && !rd_en: occ_d = occ_q + 2'd1;
      !wr_en && rd_en: occ_d = occ_q - 2'd1;
      default: ;
    endcase
    if (clr) begin
      head_d = 1'b0;
      occ_d  = 2'd0;
    end
  end

  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      occ_q  <= occ_d;
    end
  end

  // data storage needs no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dual_port_sram_fifo_ctrl.sv
// FIFO controller over a dual-port SRAM: port A writes, port B reads.
// SRAM_FIFO_ALMOST_FLAGS_EN adds Almost_Full_Out/Almost_Empty_Out.
module dual_port_sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Flush_In,
  dual_port_sram_fifo_ctrl_if.slave fifo_if,
  output logic [ADDR_WIDTH:0]   Count_Out,
  output logic                  Full_Out,
  output logic                  Empty_Out,
  output logic [DATA_WIDTH-1:0] Sram_A_Data_Out,
  output logic [ADDR_WIDTH-1:0] Sram_A_Address_Out,
  output logic                  Sram_A_Write_Enable_Out,
  output logic                  Sram_A_Read_Enable_Out,
  output logic [ADDR_WIDTH-1:0] Sram_B_Address_Out,
  output logic                  Sram_B_Read_Enable_Out,
  output logic                  Sram_B_Write_Enable_Out,
  output logic [DATA_WIDTH-1:0] Sram_B_Data_Out,
  input  logic [DATA_WIDTH-1:0] Sram_B_Data_In
`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  Almost_Full_Out,
  output logic                  Almost_Empty_Out
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [ADDR_WIDTH:0]   sram_cnt_q;
  logic [ADDR_WIDTH:0]   sram_cnt_d;
  logic                  rd_en_q;
  logic                  rd_en_d;
  logic                  inflight_q;
  logic                  inflight_d;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            load;
  logic [1:0]            buf_occ;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_data;

  sram_fifo_out_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk     (Clk_In),
    .rst_n   (Reset_In),
    .clr     (Flush_In),
    .wr_en   (inflight_q),
    .wr_data (Sram_B_Data_In),
    .rd_en   (pop),
    .occ     (buf_occ),
    .valid   (buf_valid),
    .rd_data (buf_data)
  );

  // handshakes, occupancy and read-issue decision
  always_comb begin
    Count_Out = sram_cnt_q
              + (ADDR_WIDTH+1)'(buf_occ)
              + (ADDR_WIDTH+1)'(rd_en_q)
              + (ADDR_WIDTH+1)'(inflight_q);
    Full_Out  = (Count_Out == FULL_CNT);
    Empty_Out = (Count_Out == '0);
    fifo_if.Wr_Ready_Out =
      Reset_In && !Full_Out && !Flush_In;
    fifo_if.Rd_Valid_Out = buf_valid;
    fifo_if.Rd_Data_Out  = buf_data;
    push  = fifo_if.Wr_Valid_In && fifo_if.Wr_Ready_Out;
    pop   = buf_valid && fifo_if.Rd_Ready_In;
    load  = 3'(buf_occ) + 3'(rd_en_q) + 3'(inflight_q);
    issue = !Flush_In
         && (sram_cnt_q != '0)
         && (load < (3'd2 + 3'(pop)));
  end

  // SRAM port drive: A writes on push, B reads from registered request
  always_comb begin
    Sram_A_Write_Enable_Out = push;
    Sram_A_Address_Out      = wr_ptr_q;
    Sram_A_Data_Out         = fifo_if.Wr_Data_In;
    Sram_A_Read_Enable_Out  = 1'b0;
    Sram_B_Read_Enable_Out  = rd_en_q;
    Sram_B_Address_Out      = rd_addr_q;
    Sram_B_Write_Enable_Out = 1'b0;
    Sram_B_Data_Out         = '0;
  end

  // pointer, word-count and read-pipeline next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_addr_d  = rd_addr_q;
    sram_cnt_d = sram_cnt_q
               + (ADDR_WIDTH+1)'(push)
               - (ADDR_WIDTH+1)'(issue);
    rd_en_d    = issue;
    inflight_d = rd_en_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (issue) begin
      rd_addr_d = rd_ptr_q;
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
    end
    if (Flush_In) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_addr_d  = '0;
      sram_cnt_d = '0;
      rd_en_d    = 1'b0;
      inflight_d = 1'b0;
    end
  end

  // controller state with synchronous active-low reset
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_addr_q  <= '0;
      sram_cnt_q <= '0;
      rd_en_q    <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_addr_q  <= rd_addr_d;
      sram_cnt_q <= sram_cnt_d;
      rd_en_q    <= rd_en_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef SRAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_LVL =
    FULL_CNT - (ADDR_WIDTH+1)'(ALMOST_THRESHOLD);
  localparam logic [ADDR_WIDTH:0] AE_LVL =
    (ADDR_WIDTH+1)'(ALMOST_THRESHOLD);

  // threshold flags straight from the occupancy sum
  always_comb begin
    Almost_Full_Out  = (Count_Out >= AF_LVL);
    Almost_Empty_Out = (Count_Out <= AE_LVL);
  end
`endif

endmodule

// File: doc/dual_port_sram_fifo_ctrl.md
DUAL_PORT_SRAM_FIFO_CTRL -- requirements
Module: dual_port_sram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-003 Parameter ADDR_WIDTH, default 8, SHALL set the SRAM address width (DEPTH = 2**ADDR_WIDTH = 256).
REQ-004 Clk_In  input  1  SHALL be the sole clock; all logic updates on its rising edge.
REQ-005 Reset_In  input  1  SHALL be the synchronous active-low reset.
REQ-006 Flush_In  input  1  SHALL request a synchronous FIFO clear.
REQ-007 Wr_Valid_In  input  1 / Wr_Data_In  input  DATA_WIDTH / Wr_Ready_Out  output  1  SHALL form the push handshake.
REQ-008 Rd_Valid_Out  output  1 / Rd_Data_Out  output  DATA_WIDTH / Rd_Ready_In  input  1  SHALL form the pop handshake.
REQ-009 Count_Out  output  ADDR_WIDTH+1 / Full_Out  output  1 / Empty_Out  output  1  SHALL report total occupancy.
REQ-010 Sram_A_Data_Out  output  DATA_WIDTH / Sram_A_Address_Out  output  ADDR_WIDTH / Sram_A_Write_Enable_Out  output  1 / Sram_A_Read_Enable_Out  output  1  SHALL drive SRAM Port A (write-only).
REQ-011 Sram_B_Address_Out  output  ADDR_WIDTH / Sram_B_Read_Enable_Out  output  1 / Sram_B_Write_Enable_Out  output  1 / Sram_B_Data_Out  output  DATA_WIDTH / Sram_B_Data_In  input  DATA_WIDTH  SHALL drive and return SRAM Port B (read-only).

Function
REQ-012 A push SHALL occur on a cycle with Wr_Valid_In && Wr_Ready_Out; a pop SHALL occur on a cycle with Rd_Valid_Out && Rd_Ready_In.
REQ-013 On a push, Sram_A_Write_Enable_Out SHALL be 1 combinationally, with address = write pointer and data = Wr_Data_In; the write pointer SHALL increment modulo DEPTH.
REQ-014 Sram_A_Read_Enable_Out, Sram_B_Write_Enable_Out and Sram_B_Data_Out SHALL be constant 0.
REQ-015 The SRAM read data SHALL be treated as valid on Sram_B_Data_In exactly one cycle after Sram_B_Read_Enable_Out is high (in-flight flag).
REQ-016 A read SHALL be issued (read enable 1, address = read pointer, pointer +1 modulo DEPTH) when the SRAM word count > 0 and (output-buffer occupancy + in-flight − pop this cycle) < 2.
REQ-017 Returning read data SHALL be written into a 2-entry output buffer; Rd_Data_Out SHALL be the oldest entry; Rd_Valid_Out = occupancy > 0.
REQ-018 Data SHALL hold stable while Rd_Valid_Out && !Rd_Ready_In.
REQ-019 Count_Out SHALL equal SRAM words + in-flight + buffer occupancy, range 0..DEPTH; Full_Out = (Count_Out == DEPTH); Empty_Out = (Count_Out == 0).
REQ-020 Wr_Ready_Out SHALL be !Full_Out && !Flush_In; a push and a pop on the same full cycle SHALL accept the pop only.
REQ-021 A word pushed at edge N SHALL first appear on Rd_Valid_Out after edge N+3 when the FIFO was empty and Rd_Ready_In is 1.
REQ-022 Simultaneous push and pop at non-full, non-empty occupancy SHALL leave Count_Out unchanged.
REQ-023 Pointers SHALL wrap from DEPTH−1 to 0 with no loss or reorder of data.
REQ-024 Flush_In = 1 SHALL, at the next edge, zero both pointers, the counts and buffer occupancy, and discard any in-flight read; no read is issued on the flush cycle.

Reset
REQ-025 With Reset_In = 0 at an edge, pointers, counts, in-flight flag and buffer occupancy SHALL clear, so that Rd_Valid_Out = 0, Count_Out = 0, Empty_Out = 1, Full_Out = 0, Wr_Ready_Out = 1 (after release), all SRAM enables = 0.
REQ-026 Reset asserted mid-operation SHALL discard all stored and in-flight data; SRAM contents are not cleared.

Configuration
REQ-027 Macro SRAM_FIFO_ALMOST_FLAGS_EN defined SHALL add outputs Almost_Full_Out (Count_Out >= DEPTH−4) and Almost_Empty_Out (Count_Out <= 4), both registered-free combinational from Count_Out; undefined, these ports SHALL not exist.

Structure
REQ-028 Package sram_fifo_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, DEPTH, ALMOST_THRESHOLD = 4 and typedefs addr_t, data_t, count_t.
REQ-029 The 2-entry output buffer SHALL be sub-module sram_fifo_out_buffer; the block SHALL connect to the 32-bit dual-port SRAM with no glue logic.

Verification
REQ-030 Reset, push 0xDEADBEEF at edge 5, Rd_Ready_In = 1 -> Rd_Valid_Out high after edge 8 with 0xDEADBEEF, Count_Out 1 -> 0.
REQ-031 Push 256 words 0..255, no pops -> Full_Out = 1, Wr_Ready_Out = 0, 257th push rejected; drain -> 0..255 in order, Empty_Out = 1.
REQ-032 Continuous push/pop for 600 words with random Rd_Ready_In -> wrap twice, order preserved, no overflow or underflow.
REQ-033 At Count_Out = 256 drive Wr_Valid_In and Rd_Ready_In -> one pop, push refused, Count_Out = 255.
REQ-034 Flush_In on a cycle with read in flight and Count_Out = 10 -> next cycle Count_Out = 0, Rd_Valid_Out = 0, stale word never delivered.
REQ-035 Reset_In = 0 with Count_Out = 50 -> Count_Out = 0, Empty_Out = 1; with SRAM_FIFO_ALMOST_FLAGS_EN, Almost_Empty_Out = 1 at Count_Out = 4, 0 at 5.
